stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//  Sequencer that runs the 8x16 two-read/one-write register file as a LIFO stack.
//  Accepts PUSH/POP/DUP/SWAP commands over a valid/ready handshake. Drives the file's
//  wr/wr_addr/rd_addr_a/rd_addr_b/d_in ports and returns one response per command.
//  Sits between the stack's user logic and the register file.
// PARAMETERS
//  DW     16  data width; must match the register file
//  AW     3   address width; DEPTH = 2**AW
//  DEPTH  8   stack capacity; fixed by the register file (8 entries)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   asynchronous, active-low; shares the net with the register file reset
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   controller can accept (high only in IDLE)
//  cmd_op     in   2   00 PUSH, 01 POP, 10 DUP, 11 SWAP
//  cmd_data   in   DW  push operand; ignored by other ops
//  rsp_valid  out  1   one-cycle response pulse; no backpressure
//  rsp_data   out  DW  POP: popped value; DUP: duplicated value; PUSH/SWAP/error: 0
//  rsp_err    out  1   command rejected (overflow/underflow); stack unchanged
//  count      out  AW+1  occupancy, 0..DEPTH
//  empty      out  1   count==0
//  full       out  1   count==DEPTH
//  rf_wr      out  1   to register file wr
//  rf_wr_addr out  AW  to register file wr_addr
//  rf_rd_a    out  AW  to register file rd_addr_a
//  rf_rd_b    out  AW  to register file rd_addr_b
//  rf_d_in    out  DW  to register file d_in
//  rf_q_a     in   DW  from register file d_out_a (combinational read)
//  rf_q_b     in   DW  from register file d_out_b (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE, sp=0, rsp_valid=0, rsp_data=0, rsp_err=0. All rf_* outputs are 0.
//   Reset mid-command aborts it: no write, no response.
//  sp is AW+1 bits. Top of stack = sp-1. count=sp.
//  FSM: IDLE -> EXEC -> [SWAP2] -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid, latch op/data into registers and go to EXEC.
//    Legality check uses sp at accept time:
//    PUSH needs sp<DEPTH; POP needs sp>=1; DUP needs 1<=sp<DEPTH; SWAP needs sp>=2.
//  - EXEC: driven from registered op only; rf_wr is 0 if the op is illegal.
//    PUSH: rf_wr=1, wr_addr=sp, d_in=data, sp+=1.
//    POP: rd_a=sp-1, capture q_a to rsp_data, sp-=1.
//    DUP: rd_a=sp-1, rf_wr=1, wr_addr=sp, d_in=q_a, capture q_a, sp+=1.
//    SWAP: rd_a=sp-1, rd_b=sp-2, rf_wr=1, wr_addr=sp-1, d_in=q_b, tmp<=q_a, go to SWAP2.
//    Illegal op: go to RESP with err. An illegal SWAP skips SWAP2.
//  - SWAP2: rf_wr=1, wr_addr=sp-2, d_in=tmp; sp unchanged.
//  - RESP: rsp_valid=1 for exactly 1 cycle. rsp_data/rsp_err hold until the next RESP.
//    cmd_ready=0.
//  Latency: accept at edge N -> rsp_valid high in cycle N+2 (SWAP: N+3).
//   Next accept no earlier than edge N+3 (SWAP: N+4).
//  Address arithmetic is modulo 2**AW on sp[AW-1:0]. sp itself never wraps.
//   Overflow/underflow is reported only via rsp_err.
//  rf_* outputs are 0 in IDLE and RESP, so the register file sees no stray writes.
//  cmd_valid while cmd_ready=0 is ignored. The requester must hold cmd_valid until accepted.
// CONFIGURATION
//  STACK_HWM_EN defined: adds output hwm [AW:0], the high-water mark of sp.
//   Resets to 0 and updates to max(hwm, sp_next) every cycle. A 1-cycle pulse on input
//   hwm_clr sets hwm to the current sp.
//  STACK_HWM_EN undefined: hwm and hwm_clr ports and their logic are absent.
//   All other behaviour is identical.
// TESTING
//  1. Reset low then high -> count=0, empty=1, full=0, cmd_ready=1, rf_wr=0.
//  2. PUSH 0x1111, 0x2222, POP -> rsp_data=0x2222, err=0, count=1.
//     Response timing: rsp_valid 2 cycles after each accept.
//  3. PUSH 0xA, 0xB, SWAP, POP, POP -> pops return 0xA then 0xB.
//     SWAP response arrives 3 cycles after accept.
//  4. 8 PUSHes (0x0..0x7) -> full=1. 9th PUSH 0xFFFF -> rsp_err=1, no rf_wr pulse, count=8.
//     8 POPs return 0x7..0x0.
//  5. Empty stack: POP, DUP, SWAP each -> rsp_err=1, rsp_data=0, count=0.
//     With 1 entry (0x5): SWAP -> err=1. DUP -> rsp_data=0x5, count=2.
//  6. Assert reset during EXEC of a PUSH -> no rsp_valid, count=0, cmd_ready=1 after release.
//     With STACK_HWM_EN: 3 PUSH, 2 POP -> hwm=3. After hwm_clr -> hwm=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// ============================================================================
//  Module      : stack_ctrl
//  Description : Sequencer that runs an 8x16 two-read/one-write register file
//                as a LIFO stack. Accepts PUSH/POP/DUP/SWAP commands over a
//                valid/ready handshake and returns one response per command.
//                Optional feature macro: STACK_HWM_EN (adds hwm_clr input and
//                hwm output tracking the high-water mark of the stack pointer).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          reset,
`ifdef STACK_HWM_EN
    input  logic          hwm_clr,
    output logic [AW:0]   hwm,
`endif
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          rf_wr,
    output logic [AW-1:0] rf_wr_addr,
    output logic [AW-1:0] rf_rd_a,
    output logic [AW-1:0] rf_rd_b,
    output logic [DW-1:0] rf_d_in,
    input  logic [DW-1:0] rf_q_a,
    input  logic [DW-1:0] rf_q_b
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DUP  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SWAP2 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [AW:0] DEPTH_SP = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_SP   = (AW+1)'(1);
    localparam logic [AW:0] TWO_SP   = (AW+1)'(2);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [AW:0]   sp;
    logic [AW:0]   sp_next;
    logic [1:0]    op_q;
    logic [DW-1:0] data_q;
    logic          op_err;
    logic          accept_err;
    logic [DW-1:0] tmp;
    logic [AW-1:0] sp_addr;
    logic [AW-1:0] top_addr;
    logic [AW-1:0] sec_addr;

    // Register file addresses wrap modulo DEPTH; sp itself never wraps.
    assign sp_addr  = sp[AW-1:0];
    assign top_addr = sp_addr - AW'(1);
    assign sec_addr = sp_addr - AW'(2);

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign count     = sp;
    assign empty     = (sp == '0);
    assign full      = (sp == DEPTH_SP);

    // Legality of the offered command, judged against the current occupancy.
    always_comb begin
        accept_err = 1'b0;
        case (cmd_op)
            OP_PUSH: accept_err = (sp >= DEPTH_SP);
            OP_POP:  accept_err = (sp == '0);
            OP_DUP:  accept_err = (sp == '0) || (sp >= DEPTH_SP);
            OP_SWAP: accept_err = (sp < TWO_SP);
            default: accept_err = 1'b1;
        endcase
    end

    // Next-state, next-sp and register-file port drive; rf ports idle outside EXEC/SWAP2.
    always_comb begin
        state_next = state;
        sp_next    = sp;
        rf_wr      = 1'b0;
        rf_wr_addr = '0;
        rf_rd_a    = '0;
        rf_rd_b    = '0;
        rf_d_in    = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_RESP;
                if (!op_err) begin
                    case (op_q)
                        OP_PUSH: begin
                            rf_wr      = 1'b1;
                            rf_wr_addr = sp_addr;
                            rf_d_in    = data_q;
                            sp_next    = sp + ONE_SP;
                        end
                        OP_POP: begin
                            rf_rd_a = top_addr;
                            sp_next = sp - ONE_SP;
                        end
                        OP_DUP: begin
                            rf_rd_a    = top_addr;
                            rf_wr      = 1'b1;
                            rf_wr_addr = sp_addr;
                            rf_d_in    = rf_q_a;
                            sp_next    = sp + ONE_SP;
                        end
                        OP_SWAP: begin
                            // Second-from-top moves up now; old top is parked in tmp.
                            rf_rd_a    = top_addr;
                            rf_rd_b    = sec_addr;
                            rf_wr      = 1'b1;
                            rf_wr_addr = top_addr;
                            rf_d_in    = rf_q_b;
                            state_next = S_SWAP2;
                        end
                        default: ;
                    endcase
                end
            end
            S_SWAP2: begin
                rf_wr      = 1'b1;
                rf_wr_addr = sec_addr;
                rf_d_in    = tmp;
                state_next = S_RESP;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and stack pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            sp    <= '0;
        end else begin
            state <= state_next;
            sp    <= sp_next;
        end
    end

    // Latch the accepted command together with its legality verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_PUSH;
            data_q <= '0;
            op_err <= 1'b0;
        end else if (state == S_IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            op_err <= accept_err;
        end
    end

    // Capture the read value during EXEC: response payload and the SWAP scratch copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmp      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == S_EXEC) begin
            tmp     <= rf_q_a;
            rsp_err <= op_err;
            if (!op_err && (op_q == OP_POP || op_q == OP_DUP)) begin
                rsp_data <= rf_q_a;
            end else begin
                rsp_data <= '0;
            end
        end
    end

`ifdef STACK_HWM_EN
    // High-water mark of sp; a clear pulse reloads it with the present occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= sp;
        end else if (sp_next > hwm) begin
            hwm <= sp_next;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
// ============================================================================
//  Module      : tb_stack_ctrl
//  Description : Directed self-checking bench for stack_ctrl with a behavioural
//                8x16 register file attached. Covers STACK_HWM_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_ctrl;

    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] DUP  = 2'b10;
    localparam logic [1:0] SWAP = 2'b11;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        rf_wr;
    logic [2:0]  rf_wr_addr;
    logic [2:0]  rf_rd_a;
    logic [2:0]  rf_rd_b;
    logic [15:0] rf_d_in;
    logic [15:0] rf_q_a;
    logic [15:0] rf_q_b;
`ifdef STACK_HWM_EN
    logic        hwm_clr;
    logic [3:0]  hwm;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] mem [8];

    stack_ctrl dut (
        .clk        (clk),
        .reset      (reset),
`ifdef STACK_HWM_EN
        .hwm_clr    (hwm_clr),
        .hwm        (hwm),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .rf_wr      (rf_wr),
        .rf_wr_addr (rf_wr_addr),
        .rf_rd_a    (rf_rd_a),
        .rf_rd_b    (rf_rd_b),
        .rf_d_in    (rf_d_in),
        .rf_q_a     (rf_q_a),
        .rf_q_b     (rf_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: synchronous write, combinational reads.
    always @(posedge clk) begin
        if (rf_wr) mem[rf_wr_addr] <= rf_d_in;
    end
    assign rf_q_a = mem[rf_rd_a];
    assign rf_q_b = mem[rf_rd_b];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command (called just after a falling edge) and check its response.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [15:0] d,
                          input logic [15:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_wr, input int exp_cnt);
        int lat;
        int wrs;
        lat = 0;
        wrs = 0;
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
            if (rf_wr) wrs++;
        end
        check({tag, ".lat"},   32'(lat),      32'(exp_lat));
        check({tag, ".data"},  32'(rsp_data), 32'(exp_data));
        check({tag, ".err"},   32'(rsp_err),  32'(exp_err));
        check({tag, ".wrs"},   32'(wrs),      32'(exp_wr));
        check({tag, ".count"}, 32'(count),    32'(exp_cnt));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, ".hold"},  32'(rsp_data),  32'(exp_data));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 16'h0;
`ifdef STACK_HWM_EN
        hwm_clr   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.count",    32'(count),     32'd0);
        check("rst.empty",    32'(empty),     32'd1);
        check("rst.full",     32'(full),      32'd0);
        check("rst.ready",    32'(cmd_ready), 32'd1);
        check("rst.rf_wr",    32'(rf_wr),     32'd0);
        check("rst.rsp_valid",32'(rsp_valid), 32'd0);
        check("rst.rsp_data", 32'(rsp_data),  32'd0);
        check("rst.rsp_err",  32'(rsp_err),   32'd0);

        // Basic push/pop
        do_cmd("p1",  PUSH, 16'h1111, 16'h0000, 1'b0, 2, 1, 1);
        do_cmd("p2",  PUSH, 16'h2222, 16'h0000, 1'b0, 2, 1, 2);
        do_cmd("pop1",POP,  16'h0000, 16'h2222, 1'b0, 2, 0, 1);
        do_cmd("pop2",POP,  16'h0000, 16'h1111, 1'b0, 2, 0, 0);

        // Swap
        do_cmd("sa",  PUSH, 16'h000A, 16'h0000, 1'b0, 2, 1, 1);
        do_cmd("sb",  PUSH, 16'h000B, 16'h0000, 1'b0, 2, 1, 2);
        do_cmd("swap",SWAP, 16'h0000, 16'h0000, 1'b0, 3, 2, 2);
        do_cmd("sp1", POP,  16'h0000, 16'h000A, 1'b0, 2, 0, 1);
        do_cmd("sp2", POP,  16'h0000, 16'h000B, 1'b0, 2, 0, 0);

        // Fill to capacity, overflow, drain
        for (int i = 0; i < 8; i++)
            do_cmd($sformatf("fill%0d", i), PUSH, 16'(i), 16'h0000, 1'b0, 2, 1, i + 1);
        check("full.flag",  32'(full),  32'd1);
        check("full.empty", 32'(empty), 32'd0);
        do_cmd("ovf",     PUSH, 16'hFFFF, 16'h0000, 1'b1, 2, 0, 8);
        do_cmd("dup_full",DUP,  16'h0000, 16'h0000, 1'b1, 2, 0, 8);
        for (int i = 7; i >= 0; i--)
            do_cmd($sformatf("drain%0d", i), POP, 16'h0, 16'(i), 1'b0, 2, 0, i);
        check("drain.empty", 32'(empty), 32'd1);

        // Underflow on empty stack
        do_cmd("e_pop", POP,  16'h0000, 16'h0000, 1'b1, 2, 0, 0);
        do_cmd("e_dup", DUP,  16'h0000, 16'h0000, 1'b1, 2, 0, 0);
        do_cmd("e_swap",SWAP, 16'h0000, 16'h0000, 1'b1, 2, 0, 0);

        // Single entry: swap rejected, dup allowed
        do_cmd("one",   PUSH, 16'h0005, 16'h0000, 1'b0, 2, 1, 1);
        do_cmd("o_swap",SWAP, 16'h0000, 16'h0000, 1'b1, 2, 0, 1);
        do_cmd("o_dup", DUP,  16'h0000, 16'h0005, 1'b0, 2, 1, 2);
        do_cmd("o_p1",  POP,  16'h0000, 16'h0005, 1'b0, 2, 0, 1);
        do_cmd("o_p2",  POP,  16'h0000, 16'h0005, 1'b0, 2, 0, 0);

        // Reset in the middle of a PUSH
        cmd_valid = 1'b1;
        cmd_op    = PUSH;
        cmd_data  = 16'hBEEF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort.exec_wr", 32'(rf_wr), 32'd1);
        reset = 1'b0;
        #1;
        check("abort.rf_wr", 32'(rf_wr), 32'd0);
        check("abort.count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort.norsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        check("abort.ready", 32'(cmd_ready), 32'd1);
        check("abort.count2",32'(count),     32'd0);
        check("abort.mem0",  32'(mem[0]),    32'h0005);

`ifdef STACK_HWM_EN
        // High-water mark
        check("hwm.rst", 32'(hwm), 32'd0);
        do_cmd("h1", PUSH, 16'h0001, 16'h0000, 1'b0, 2, 1, 1);
        do_cmd("h2", PUSH, 16'h0002, 16'h0000, 1'b0, 2, 1, 2);
        do_cmd("h3", PUSH, 16'h0003, 16'h0000, 1'b0, 2, 1, 3);
        do_cmd("h4", POP,  16'h0000, 16'h0003, 1'b0, 2, 0, 2);
        do_cmd("h5", POP,  16'h0000, 16'h0002, 1'b0, 2, 0, 1);
        check("hwm.peak", 32'(hwm), 32'd3);
        hwm_clr = 1'b1;
        @(negedge clk);
        hwm_clr = 1'b0;
        check("hwm.clr", 32'(hwm), 32'd1);
        @(negedge clk);
        check("hwm.hold", 32'(hwm), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
